// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle control sequencer and the ALU control decoder.
// Latency: none (types, constants and a pure match function only).
// Backpressure: not applicable.
package cpu_pkg;

    // Sequencer states; the encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    // Instruction classes produced by the opcode decoder.
    typedef enum logic [3:0] {
        IC_ILLEGAL = 4'd0,
        IC_LDUR    = 4'd1,
        IC_STUR    = 4'd2,
        IC_ADD     = 4'd3,
        IC_SUBS    = 4'd4,
        IC_SUBI    = 4'd5,
        IC_MOVZ    = 4'd6,
        IC_CBZ     = 4'd7,
        IC_B       = 4'd8
    } iclass_t;

    // ALUOp encodings seen by the ALU control decoder.
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_DP     = 2'b10;

    // Opcode field masks: 11-bit (R/D format), 9-bit (I/IW format), 8-bit (CB), 6-bit (B).
    localparam logic [31:0] MASK_OP11 = 32'hFFE0_0000;
    localparam logic [31:0] MASK_OP9  = 32'hFF80_0000;
    localparam logic [31:0] MASK_OP8  = 32'hFF00_0000;
    localparam logic [31:0] MASK_OP6  = 32'hFC00_0000;

    // Opcode match values, aligned to bit 31.
    localparam logic [31:0] OPC_LDUR = 32'hF840_0000;
    localparam logic [31:0] OPC_STUR = 32'hF800_0000;
    localparam logic [31:0] OPC_ADD  = 32'h8B00_0000;
    localparam logic [31:0] OPC_SUBS = 32'hEB00_0000;
    localparam logic [31:0] OPC_SUBI = 32'hD100_0000;
    localparam logic [31:0] OPC_MOVZ = 32'hD280_0000;
    localparam logic [31:0] OPC_CBZ  = 32'hB400_0000;
    localparam logic [31:0] OPC_B    = 32'h1400_0000;

    function automatic logic op_match(input logic [31:0] ir,
                                      input logic [31:0] mask,
                                      input logic [31:0] match);
        return (ir & mask) == match;
    endfunction

endpackage

// File: rtl/cpu_opcode_decode.sv
// Classifies an instruction word into its class and flags anything unsupported as illegal.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input word.
module cpu_opcode_decode
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output iclass_t     cls,
    output logic        illegal
);

    // The fixed-width opcode fields do not overlap, so the order of the chain is not significant.
    always_comb begin
        cls = IC_ILLEGAL;
        if      (op_match(ir, MASK_OP11, OPC_LDUR)) cls = IC_LDUR;
        else if (op_match(ir, MASK_OP11, OPC_STUR)) cls = IC_STUR;
        else if (op_match(ir, MASK_OP11, OPC_ADD))  cls = IC_ADD;
        else if (op_match(ir, MASK_OP11, OPC_SUBS)) cls = IC_SUBS;
        else if (op_match(ir, MASK_OP9,  OPC_SUBI)) cls = IC_SUBI;
        else if (op_match(ir, MASK_OP9,  OPC_MOVZ)) cls = IC_MOVZ;
        else if (op_match(ir, MASK_OP8,  OPC_CBZ))  cls = IC_CBZ;
        else if (op_match(ir, MASK_OP6,  OPC_B))    cls = IC_B;
        illegal = (cls == IC_ILLEGAL);
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer that drives the datapath enables, the memory handshakes and the PC update.
// Latency: B/CBZ/CMP 3 cycles, ADD/SUBI/MOVZ/STUR 4 cycles, LDUR 5 cycles, plus one cycle per memory wait.
// Backpressure: req is held until ack is seen; after TIMEOUT unacknowledged req cycles the core parks in TRAP until reset.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [31:0] instr,
    output logic [1:0]  alu_op,
    output logic        alu_src_imm,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        flags_write,
    input  logic        alu_zero,
    output logic        pc_write,
    output logic        pc_src_branch,
    output logic        trap,
    output logic [2:0]  state
);

    // Last count value before the timeout fires: req is then high for exactly TIMEOUT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  wait_cnt;
    iclass_t     cls;
    logic        illegal;
    logic        req_stall;
    logic        is_ldur;
    logic        is_stur;

    cpu_opcode_decode u_decode (
        .ir      (instr),
        .cls     (cls),
        .illegal (illegal)
    );

    assign is_ldur = (cls == IC_LDUR);
    assign is_stur = (cls == IC_STUR);
    assign state   = state_q;

    // A cycle where the current state's request goes unacknowledged.
    assign req_stall = ((state_q == ST_FETCH) && !imem_ack) ||
                       ((state_q == ST_MEM)   && !dmem_ack);

    // State register; reset wins over any in-flight ack.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    // Instruction register, loaded on the fetch handshake.
    always_ff @(posedge clk) begin
        if (!rst_n)                                 instr <= 32'h0;
        else if ((state_q == ST_FETCH) && imem_ack) instr <= imem_rdata;
    end

    // Wait counter: restarts on every state change, counts unacknowledged req cycles.
    always_ff @(posedge clk) begin
        if (!rst_n)                  wait_cnt <= 8'h0;
        else if (state_d != state_q) wait_cnt <= 8'h0;
        else if (req_stall)          wait_cnt <= wait_cnt + 8'h1;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack)                  state_d = ST_DECODE;
                else if (wait_cnt >= WAIT_LAST) state_d = ST_TRAP;
            end
            ST_DECODE: state_d = illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                case (cls)
                    IC_B, IC_CBZ, IC_SUBS: state_d = ST_FETCH;
                    IC_LDUR, IC_STUR:      state_d = ST_MEM;
                    default:               state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack)                   state_d = is_stur ? ST_FETCH : ST_WB;
                else if (wait_cnt >= WAIT_LAST) state_d = ST_TRAP;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    // Output logic: Moore enables from the state, plus the ack/zero-qualified PC controls.
    always_comb begin
        imem_req      = (state_q == ST_FETCH);
        dmem_req      = (state_q == ST_MEM);
        dmem_we       = (state_q == ST_MEM) && is_stur;
        alu_op        = ALUOP_ADD;
        alu_src_imm   = 1'b0;
        reg_write     = (state_q == ST_WB);
        mem_to_reg    = (state_q == ST_WB) && is_ldur;
        flags_write   = (state_q == ST_EXEC) && (cls == IC_SUBS);
        pc_write      = 1'b0;
        pc_src_branch = 1'b0;
        trap          = (state_q == ST_TRAP);

        if ((state_q == ST_DECODE) || (state_q == ST_EXEC) ||
            (state_q == ST_MEM)    || (state_q == ST_WB)) begin
            case (cls)
                IC_CBZ, IC_B:                   alu_op = ALUOP_BRANCH;
                IC_ADD, IC_SUBS, IC_SUBI, IC_MOVZ: alu_op = ALUOP_DP;
                default:                        alu_op = ALUOP_ADD;
            endcase
            alu_src_imm = (cls == IC_SUBI) || (cls == IC_MOVZ) || is_ldur || is_stur;
        end

        case (state_q)
            ST_EXEC: begin
                pc_write      = (cls == IC_B) || (cls == IC_CBZ) || (cls == IC_SUBS);
                pc_src_branch = (cls == IC_B) || ((cls == IC_CBZ) && alu_zero);
            end
            ST_MEM:  pc_write = dmem_ack && is_stur;
            ST_WB:   pc_write = 1'b1;
            default: pc_write = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for the control sequencer: per-cycle state and control checks on hand-built vectors.
// Latency: inputs change 1ns after a rising edge, outputs are checked 2ns after it.
// Backpressure: memory acks are driven by the bench to create wait and timeout cases.
module tb_cpu_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] instr;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_to_reg;
    logic        flags_write;
    logic        alu_zero;
    logic        pc_write;
    logic        pc_src_branch;
    logic        trap;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD  = 32'h8B02_0020;
    localparam logic [31:0] I_LDUR = 32'hF840_0020;
    localparam logic [31:0] I_STUR = 32'hF800_0020;
    localparam logic [31:0] I_CBZ  = 32'hB400_0040;
    localparam logic [31:0] I_CMP  = 32'hEB01_001F;

    cpu_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ack      (dmem_ack),
        .instr         (instr),
        .alu_op        (alu_op),
        .alu_src_imm   (alu_src_imm),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .flags_write   (flags_write),
        .alu_zero      (alu_zero),
        .pc_write      (pc_write),
        .pc_src_branch (pc_src_branch),
        .trap          (trap),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and land 2ns past the edge, where outputs have settled.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // From a FETCH cycle: present a word with a zero-wait ack and move into DECODE.
    task automatic fetch(input logic [31:0] word);
        imem_rdata = word;
        imem_ack   = 1'b1;
        #1;
        chk("fetch_state", 32'(state), 32'd0);
        chk("fetch_req", 32'(imem_req), 32'd1);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("decode_state", 32'(state), 32'd1);
        chk("decode_ir", instr, word);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        dmem_ack = 1'b0; alu_zero = 1'b0;
        tick(); tick();

        // Reset state.
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ir", instr, 32'h0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_ctrl", {reg_write, pc_write, flags_write, mem_to_reg, alu_op}, 32'd0);
        rst_n = 1'b1;

        // ADD: FETCH, DECODE, EXEC, WB.
        fetch(I_ADD);
        chk("add_aluop_dec", 32'(alu_op), 32'd2);
        tick();
        chk("add_exec_state", 32'(state), 32'd2);
        chk("add_exec_pcw", 32'(pc_write), 32'd0);
        chk("add_exec_rw", 32'(reg_write), 32'd0);
        tick();
        chk("add_wb_state", 32'(state), 32'd4);
        chk("add_wb_rw_pcw", {reg_write, pc_write, mem_to_reg}, 32'b110);
        chk("add_wb_aluop", 32'(alu_op), 32'd2);
        tick();
        chk("add_back_fetch", 32'(state), 32'd0);

        // LDUR with three dmem wait cycles: 8 cycles in total.
        n = 1;
        fetch(I_LDUR); n++;
        chk("ldur_aluop", {alu_op, alu_src_imm}, 32'b001);
        tick(); n++;
        chk("ldur_exec_state", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick(); n++;
            chk("ldur_mem_wait", {state, dmem_req, dmem_we, pc_write, imem_req}, 32'b011_1000);
        end
        dmem_ack = 1'b1;
        #1;
        chk("ldur_mem_ack", {dmem_req, dmem_we, pc_write}, 32'b100);
        tick(); n++;
        dmem_ack = 1'b0;
        #1;
        chk("ldur_wb", {state, reg_write, mem_to_reg, pc_write, dmem_req}, 32'b100_1110);
        tick(); n++;
        chk("ldur_back_fetch", 32'(state), 32'd0);
        chk("ldur_cycles", 32'(n), 32'd8);

        // STUR zero-wait: store direction and PC update on the ack cycle.
        fetch(I_STUR);
        tick(); tick();
        dmem_ack = 1'b1;
        #1;
        chk("stur_mem", {state, dmem_req, dmem_we, pc_write}, 32'b011_111);
        tick();
        dmem_ack = 1'b0;
        chk("stur_back_fetch", {state, reg_write}, 32'b000_0);

        // CBZ taken then not taken.
        fetch(I_CBZ);
        chk("cbz_aluop", 32'(alu_op), 32'd1);
        tick();
        alu_zero = 1'b1;
        #1;
        chk("cbz_taken", {state, pc_write, pc_src_branch, reg_write}, 32'b010_110);
        tick();
        chk("cbz_taken_fetch", 32'(state), 32'd0);
        fetch(I_CBZ);
        tick();
        alu_zero = 1'b0;
        #1;
        chk("cbz_not_taken", {state, pc_write, pc_src_branch, reg_write}, 32'b010_100);
        tick();
        chk("cbz_nt_fetch", 32'(state), 32'd0);

        // CMP: flags pulse in EXEC only, no register write.
        fetch(I_CMP);
        tick();
        chk("cmp_exec", {state, flags_write, pc_write, reg_write}, 32'b010_110);
        tick();
        chk("cmp_after", {state, flags_write, reg_write}, 32'b000_00);

        // Illegal word traps after DECODE and stays there.
        fetch(32'h0000_0000);
        tick();
        chk("ill_trap", {state, trap, imem_req, dmem_req}, 32'b111_100);
        imem_ack = 1'b1;
        tick(); tick();
        chk("ill_sticky", {state, trap, imem_req, dmem_req, pc_write}, 32'b111_1000);
        imem_ack = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("ill_reset", {state, trap}, 32'b000_0);
        rst_n = 1'b1;

        // Reset in the middle of MEM: request drops, the coincident ack is ignored.
        fetch(I_LDUR);
        tick(); tick();
        chk("midmem_req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        dmem_ack = 1'b1;
        tick();
        chk("midmem_reset", {state, dmem_req, reg_write}, 32'b000_00);
        dmem_ack = 1'b0;
        rst_n = 1'b1;

        // Fetch timeout: req high for exactly 255 cycles before TRAP.
        n = 0;
        while (imem_req && n < 400) begin
            n++;
            tick();
        end
        chk("tmo_req_cycles", 32'(n), 32'd255);
        chk("tmo_trap", {state, trap, imem_req}, 32'b111_10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
